// File: rtl/axi_sram_slave_if.sv
// axi_channel: AXI4 channel bundle shared by the interconnect, its masters
// and the axi_sram_slave endpoint. A single clock drives every agent on it.
interface axi_channel #(
    parameter int ID_WIDTH   = 8,
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // Write address channel
    logic [ID_WIDTH-1:0]   aw_id;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [7:0]            aw_len;
    logic [2:0]            aw_size;
    logic [1:0]            aw_burst;
    logic                  aw_valid;
    logic                  aw_ready;

    // Write data channel
    logic [DATA_WIDTH-1:0] w_data;
    logic [STRB_WIDTH-1:0] w_strb;
    logic                  w_last;
    logic                  w_valid;
    logic                  w_ready;

    // Write response channel
    logic [ID_WIDTH-1:0]   b_id;
    logic [1:0]            b_resp;
    logic [USER_WIDTH-1:0] b_user;
    logic                  b_valid;
    logic                  b_ready;

    // Read address channel
    logic [ID_WIDTH-1:0]   ar_id;
    logic [ADDR_WIDTH-1:0] ar_addr;
    logic [7:0]            ar_len;
    logic [2:0]            ar_size;
    logic [1:0]            ar_burst;
    logic                  ar_valid;
    logic                  ar_ready;

    // Read data channel
    logic [ID_WIDTH-1:0]   r_id;
    logic [DATA_WIDTH-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;
    logic [USER_WIDTH-1:0] r_user;
    logic                  r_valid;
    logic                  r_ready;

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI4 slave endpoint backed by an on-chip SRAM.
// One write burst and one read burst in flight at a time, independently.
// FIXED and INCR bursts always; WRAP bursts only when the macro
// AXI_SRAM_SLAVE_WRAP_EN is defined (otherwise WRAP answers SLVERR).
module axi_sram_slave #(
    parameter int ID_WIDTH   = 8,
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64,
    parameter int MEM_DEPTH  = 1024
) (
    input logic       clk,
    input logic       rst,
    axi_channel.slave slave
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int LSB        = $clog2(STRB_WIDTH);
    localparam int IDX_W      = $clog2(MEM_DEPTH);
    localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * STRB_WIDTH);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXI_SRAM_SLAVE_WRAP_EN
    localparam logic WRAP_EN = 1'b1;
`else
    localparam logic WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_READ, R_DATA} r_state_t;

    // A byte address maps onto the memory only below MEM_DEPTH words.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return {1'b0, addr} < MEM_BYTES;
    endfunction

    // Oversized beats, the reserved burst type and unsupported WRAP shapes.
    function automatic logic burst_illegal(input logic [7:0] len,
                                           input logic [2:0] size,
                                           input logic [1:0] burst);
        logic wrap_ok;
        wrap_ok = WRAP_EN && ((len == 8'd1) || (len == 8'd3) ||
                              (len == 8'd7) || (len == 8'd15));
        return (32'(size) > LSB) || (burst == 2'b11) ||
               ((burst == BURST_WRAP) && !wrap_ok);
    endfunction

    // Address of the following beat of a burst.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
`ifdef AXI_SRAM_SLAVE_WRAP_EN
        input logic [7:0]            len,
`endif
        input logic [2:0]            size,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] aligned;
        logic [ADDR_WIDTH-1:0] nxt;
`ifdef AXI_SRAM_SLAVE_WRAP_EN
        logic [ADDR_WIDTH-1:0] bound;
`endif
        step    = ADDR_WIDTH'(1) << size;
        aligned = addr & ~(step - ADDR_WIDTH'(1));
        nxt     = addr;
        case (burst)
            BURST_FIXED: nxt = addr;
            BURST_INCR:  nxt = aligned + step;
`ifdef AXI_SRAM_SLAVE_WRAP_EN
            BURST_WRAP: begin
                bound = ADDR_WIDTH'({1'b0, len} + 9'd1) << size;
                nxt   = (addr & ~(bound - ADDR_WIDTH'(1))) |
                        ((aligned + step) & (bound - ADDR_WIDTH'(1)));
            end
`endif
            default:     nxt = addr;
        endcase
        return nxt;
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Ready outputs stay low for the first cycle after a reset edge.
    logic active;

    // Write path state
    w_state_t              w_state, w_next;
    logic [ID_WIDTH-1:0]   w_id;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [7:0]            w_len;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic [7:0]            w_cnt;
    logic                  w_err;
    logic                  w_illegal;
    logic                  aw_rdy, w_rdy, b_vld;
    logic                  aw_hs, w_hs, b_hs, w_final, w_beat_ok;

    // Read path state
    r_state_t              r_state, r_next;
    logic [ID_WIDTH-1:0]   r_id_q;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [7:0]            r_cnt;
    logic                  r_illegal;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic [1:0]            r_resp_q;
    logic                  ar_rdy, r_vld, r_last_d;
    logic                  ar_hs, r_hs, r_final;

    assign aw_hs     = slave.aw_valid && aw_rdy;
    assign w_hs      = slave.w_valid && w_rdy;
    assign b_hs      = slave.b_ready && b_vld;
    assign w_final   = (w_cnt == w_len);
    assign w_beat_ok = in_range(w_addr) && !w_illegal;

    assign ar_hs   = slave.ar_valid && ar_rdy;
    assign r_hs    = slave.r_ready && r_vld;
    assign r_final = (r_cnt == r_len);

    // Track whether the previous edge saw reset.
    always_ff @(posedge clk) begin
        active <= !rst;
    end

    // Write FSM state register.
    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    // Write FSM next-state logic; the beat counter alone ends the burst.
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && w_final) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // Write FSM outputs decoded from state.
    always_comb begin
        aw_rdy = active && (w_state == W_IDLE);
        w_rdy  = (w_state == W_DATA);
        b_vld  = (w_state == W_RESP);
    end

    // Write control: id, beat counter and the sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_id      <= '0;
            w_cnt     <= '0;
            w_err     <= 1'b0;
            w_illegal <= 1'b0;
        end else if (aw_hs) begin
            w_id      <= slave.aw_id;
            w_cnt     <= '0;
            w_err     <= 1'b0;
            w_illegal <= burst_illegal(slave.aw_len, slave.aw_size, slave.aw_burst);
        end else if (w_hs) begin
            w_cnt <= w_cnt + 8'd1;
            if (!in_range(w_addr) || (slave.w_last != w_final)) w_err <= 1'b1;
        end
    end

    // Write burst descriptor and per-beat address walk.
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            w_addr  <= slave.aw_addr;
            w_len   <= slave.aw_len;
            w_size  <= slave.aw_size;
            w_burst <= slave.aw_burst;
        end else if (w_hs) begin
`ifdef AXI_SRAM_SLAVE_WRAP_EN
            w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
`else
            w_addr <= next_addr(w_addr, w_size, w_burst);
`endif
        end
    end

    // Byte-strobed SRAM write for legal, in-range beats.
    always_ff @(posedge clk) begin
        if (!rst && w_hs && w_beat_ok) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (slave.w_strb[b]) begin
                    mem[w_addr[LSB +: IDX_W]][8*b +: 8] <= slave.w_data[8*b +: 8];
                end
            end
        end
    end

    // Read FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    // Read FSM next-state logic: one SRAM fetch cycle before every beat.
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_READ;
            R_READ:  r_next = R_DATA;
            R_DATA:  if (r_hs) r_next = r_final ? R_IDLE : R_READ;
            default: r_next = R_IDLE;
        endcase
    end

    // Read FSM outputs decoded from state.
    always_comb begin
        ar_rdy   = active && (r_state == R_IDLE);
        r_vld    = (r_state == R_DATA);
        r_last_d = (r_state == R_DATA) && r_final;
    end

    // Read beat registers: held until the R handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_id_q    <= '0;
            r_cnt     <= '0;
            r_illegal <= 1'b0;
            r_data_q  <= '0;
            r_resp_q  <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                r_id_q    <= slave.ar_id;
                r_cnt     <= '0;
                r_illegal <= burst_illegal(slave.ar_len, slave.ar_size, slave.ar_burst);
            end else if (r_hs && !r_final) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (r_state == R_READ) begin
                if (in_range(r_addr) && !r_illegal) begin
                    r_data_q <= mem[r_addr[LSB +: IDX_W]];
                    r_resp_q <= RESP_OKAY;
                end else begin
                    r_data_q <= '0;
                    r_resp_q <= RESP_SLVERR;
                end
            end
        end
    end

    // Read burst descriptor and per-beat address walk.
    always_ff @(posedge clk) begin
        if (ar_hs) begin
            r_addr  <= slave.ar_addr;
            r_len   <= slave.ar_len;
            r_size  <= slave.ar_size;
            r_burst <= slave.ar_burst;
        end else if (r_hs && !r_final) begin
`ifdef AXI_SRAM_SLAVE_WRAP_EN
            r_addr <= next_addr(r_addr, r_len, r_size, r_burst);
`else
            r_addr <= next_addr(r_addr, r_size, r_burst);
`endif
        end
    end

    assign slave.aw_ready = aw_rdy;
    assign slave.w_ready  = w_rdy;
    assign slave.b_valid  = b_vld;
    assign slave.b_id     = w_id;
    assign slave.b_resp   = (w_err || w_illegal) ? RESP_SLVERR : RESP_OKAY;
    assign slave.b_user   = '0;
    assign slave.ar_ready = ar_rdy;
    assign slave.r_valid  = r_vld;
    assign slave.r_id     = r_id_q;
    assign slave.r_data   = r_data_q;
    assign slave.r_resp   = r_resp_q;
    assign slave.r_last   = r_last_d;
    assign slave.r_user   = '0;

endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: directed bench for axi_sram_slave (64-bit data, 256 words).
module tb_axi_sram_slave;
    localparam int TMO = 100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi_channel #(.ID_WIDTH(8), .ADDR_WIDTH(48), .DATA_WIDTH(64)) axi ();

    axi_sram_slave #(
        .ID_WIDTH(8), .ADDR_WIDTH(48), .DATA_WIDTH(64), .MEM_DEPTH(256)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .slave(axi)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] wbeat [16];
    logic [63:0] rbeat [16];
    logic [1:0]  rresp [16];
    logic        rlast [16];
    logic [7:0]  rid   [16];
    int          rlat;
    logic [1:0]  bresp;
    logic [7:0]  bid;
    logic        b_at_once;
    logic        b_early;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_write(input logic [7:0] id, input logic [47:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [7:0] strb);
        int n;
        axi.aw_id = id; axi.aw_addr = addr; axi.aw_len = len;
        axi.aw_size = size; axi.aw_burst = burst; axi.aw_valid = 1'b1;
        n = 0;
        while (!axi.aw_ready && n < TMO) begin @(posedge clk); #1; n++; end
        check("aw_wait", 64'(n < TMO), 64'd1);
        @(posedge clk); #1;
        axi.aw_valid = 1'b0;
        b_early = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            axi.w_data = wbeat[i]; axi.w_strb = strb;
            axi.w_last = (i == int'(len)); axi.w_valid = 1'b1;
            n = 0;
            while (!axi.w_ready && n < TMO) begin @(posedge clk); #1; n++; end
            if (n >= TMO) check("w_wait", 64'd0, 64'd1);
            b_early = b_early | axi.b_valid;
            @(posedge clk); #1;
        end
        axi.w_valid = 1'b0; axi.w_last = 1'b0;
        b_at_once = axi.b_valid;
        axi.b_ready = 1'b1;
        n = 0;
        while (!axi.b_valid && n < TMO) begin @(posedge clk); #1; n++; end
        check("b_wait", 64'(n < TMO), 64'd1);
        bresp = axi.b_resp; bid = axi.b_id;
        @(posedge clk); #1;
        axi.b_ready = 1'b0;
    endtask

    task automatic do_read(input logic [7:0] id, input logic [47:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int n;
        axi.ar_id = id; axi.ar_addr = addr; axi.ar_len = len;
        axi.ar_size = size; axi.ar_burst = burst; axi.ar_valid = 1'b1;
        n = 0;
        while (!axi.ar_ready && n < TMO) begin @(posedge clk); #1; n++; end
        check("ar_wait", 64'(n < TMO), 64'd1);
        @(posedge clk); #1;
        axi.ar_valid = 1'b0;
        axi.r_ready = 1'b1;
        for (int i = 0; i <= int'(len); i++) begin
            n = 0;
            while (!axi.r_valid && n < TMO) begin @(posedge clk); #1; n++; end
            if (n >= TMO) check("r_wait", 64'd0, 64'd1);
            if (i == 0) rlat = n + 1;
            rbeat[i] = axi.r_data; rresp[i] = axi.r_resp;
            rlast[i] = axi.r_last; rid[i] = axi.r_id;
            @(posedge clk); #1;
        end
        axi.r_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] exp3 [4];
        logic [1:0]  exp3_resp;
        logic [63:0] held;
        int          n;
        int          bcount;

        rst = 1'b1;
        axi.aw_valid = 0; axi.aw_id = 0; axi.aw_addr = 0; axi.aw_len = 0; axi.aw_size = 0; axi.aw_burst = 0;
        axi.w_valid = 0; axi.w_data = 0; axi.w_strb = 0; axi.w_last = 0;
        axi.b_ready = 0;
        axi.ar_valid = 0; axi.ar_id = 0; axi.ar_addr = 0; axi.ar_len = 0; axi.ar_size = 0; axi.ar_burst = 0;
        axi.r_ready = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_aw_ready", 64'(axi.aw_ready), 64'd0);
        check("rst_ar_ready", 64'(axi.ar_ready), 64'd0);
        check("rst_w_ready",  64'(axi.w_ready),  64'd0);
        check("rst_b_valid",  64'(axi.b_valid),  64'd0);
        check("rst_r_valid",  64'(axi.r_valid),  64'd0);
        check("rst_r_data",   axi.r_data,        64'd0);
        check("rst_b_resp",   64'(axi.b_resp),   64'd0);
        check("rst_r_last",   64'(axi.r_last),   64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rel_aw_ready", 64'(axi.aw_ready), 64'd1);
        check("rel_ar_ready", 64'(axi.ar_ready), 64'd1);

        // 1: single write then read
        wbeat[0] = 64'h1122334455667788;
        do_write(8'd3, 48'h10, 8'd0, 3'd3, 2'b01, 8'hFF);
        check("t1_bid", 64'(bid), 64'd3);
        check("t1_bresp", 64'(bresp), 64'd0);
        check("t1_buser", 64'(axi.b_user), 64'd0);
        do_read(8'd5, 48'h10, 8'd0, 3'd3, 2'b01);
        check("t1_rdata", rbeat[0], 64'h1122334455667788);
        check("t1_rid", 64'(rid[0]), 64'd5);
        check("t1_rresp", 64'(rresp[0]), 64'd0);
        check("t1_rlast", 64'(rlast[0]), 64'd1);
        check("t1_rlat", 64'(rlat), 64'd2);
        check("t1_ar_ready_after", 64'(axi.ar_ready), 64'd1);

        // 2: INCR burst of four beats
        for (int i = 0; i < 4; i++) wbeat[i] = 64'(i + 1);
        do_write(8'd1, 48'h100, 8'd3, 3'd3, 2'b01, 8'hFF);
        check("t2_b_at_once", 64'(b_at_once), 64'd1);
        check("t2_b_early", 64'(b_early), 64'd0);
        check("t2_bresp", 64'(bresp), 64'd0);
        do_read(8'd2, 48'h100, 8'd3, 3'd3, 2'b01);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_rdata%0d", i), rbeat[i], 64'(i + 1));
            check($sformatf("t2_rlast%0d", i), 64'(rlast[i]), 64'(i == 3));
        end

        // 3: WRAP read starting at the last word of a 32-byte window
        for (int i = 0; i < 4; i++) wbeat[i] = 64'hA0 + 64'(i);
        do_write(8'd1, 48'h100, 8'd3, 3'd3, 2'b01, 8'hFF);
        check("t3_fill_bresp", 64'(bresp), 64'd0);
`ifdef AXI_SRAM_SLAVE_WRAP_EN
        exp3[0] = 64'hA3; exp3[1] = 64'hA0; exp3[2] = 64'hA1; exp3[3] = 64'hA2;
        exp3_resp = 2'b00;
`else
        exp3[0] = 64'h0; exp3[1] = 64'h0; exp3[2] = 64'h0; exp3[3] = 64'h0;
        exp3_resp = 2'b10;
`endif
        do_read(8'd7, 48'h118, 8'd3, 3'd3, 2'b10);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_rdata%0d", i), rbeat[i], exp3[i]);
            check($sformatf("t3_rresp%0d", i), 64'(rresp[i]), 64'(exp3_resp));
        end
        check("t3_rlast3", 64'(rlast[3]), 64'd1);

        // 4: out-of-range write and read; word 0 must not be aliased
        wbeat[0] = 64'hCAFE;
        do_write(8'd4, 48'h0, 8'd0, 3'd3, 2'b01, 8'hFF);
        check("t4_w0_bresp", 64'(bresp), 64'd0);
        wbeat[0] = 64'hDEADBEEF;
        do_write(8'd4, 48'h800, 8'd0, 3'd3, 2'b01, 8'hFF);
        check("t4_oor_bresp", 64'(bresp), 64'd2);
        do_read(8'd4, 48'h800, 8'd0, 3'd3, 2'b01);
        check("t4_oor_rdata", rbeat[0], 64'd0);
        check("t4_oor_rresp", 64'(rresp[0]), 64'd2);
        do_read(8'd4, 48'h0, 8'd0, 3'd3, 2'b01);
        check("t4_w0_rdata", rbeat[0], 64'hCAFE);
        check("t4_w0_rresp", 64'(rresp[0]), 64'd0);

        // Illegal size (16 bytes on a 64-bit bus): SLVERR, no write
        wbeat[0] = 64'h5555;
        do_write(8'd6, 48'h0, 8'd0, 3'd4, 2'b01, 8'hFF);
        check("ill_bresp", 64'(bresp), 64'd2);
        do_read(8'd6, 48'h0, 8'd0, 3'd3, 2'b01);
        check("ill_word0", rbeat[0], 64'hCAFE);

        // 5: partial write and R backpressure
        wbeat[0] = 64'hFFFFFFFFFFFFFFFF;
        do_write(8'd9, 48'h10, 8'd0, 3'd3, 2'b01, 8'h0F);
        check("t5_bresp", 64'(bresp), 64'd0);
        axi.ar_id = 8'd9; axi.ar_addr = 48'h10; axi.ar_len = 8'd0;
        axi.ar_size = 3'd3; axi.ar_burst = 2'b01; axi.ar_valid = 1'b1;
        n = 0;
        while (!axi.ar_ready && n < TMO) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        axi.ar_valid = 1'b0;
        n = 0;
        while (!axi.r_valid && n < TMO) begin @(posedge clk); #1; n++; end
        check("t5_r_wait", 64'(n < TMO), 64'd1);
        held = axi.r_data;
        check("t5_rdata", held, 64'h11223344FFFFFFFF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("t5_hold_vld%0d", i), 64'(axi.r_valid), 64'd1);
            check($sformatf("t5_hold_data%0d", i), axi.r_data, 64'h11223344FFFFFFFF);
        end
        axi.r_ready = 1'b1;
        @(posedge clk); #1;
        axi.r_ready = 1'b0;
        check("t5_r_done", 64'(axi.r_valid), 64'd0);

        // 6: reset in the middle of a write burst
        axi.aw_id = 8'd8; axi.aw_addr = 48'h200; axi.aw_len = 8'd3;
        axi.aw_size = 3'd3; axi.aw_burst = 2'b01; axi.aw_valid = 1'b1;
        n = 0;
        while (!axi.aw_ready && n < TMO) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        axi.aw_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            axi.w_data = 64'(i); axi.w_strb = 8'hFF; axi.w_last = 1'b0; axi.w_valid = 1'b1;
            n = 0;
            while (!axi.w_ready && n < TMO) begin @(posedge clk); #1; n++; end
            @(posedge clk); #1;
        end
        axi.w_valid = 1'b0;
        axi.b_ready = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("t6_aw_ready", 64'(axi.aw_ready), 64'd0);
        check("t6_w_ready",  64'(axi.w_ready),  64'd0);
        check("t6_b_valid",  64'(axi.b_valid),  64'd0);
        check("t6_ar_ready", 64'(axi.ar_ready), 64'd0);
        check("t6_r_valid",  64'(axi.r_valid),  64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("t6_rel_aw_ready", 64'(axi.aw_ready), 64'd1);
        bcount = 0;
        for (int i = 0; i < 10; i++) begin
            if (axi.b_valid) bcount++;
            @(posedge clk); #1;
        end
        axi.b_ready = 1'b0;
        check("t6_no_b", 64'(bcount), 64'd0);
        check("t6_w_ready_idle", 64'(axi.w_ready), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
